conv_accum_requant: RTL and testbench

- Consumes the adder tree's per-kernel-window partial sums, one sum per input-channel group.
- Accumulates NUM_GROUPS consecutive valid beats into one output-pixel sum, then adds a per-output-channel bias.
- Requantizes the result with a fixed-point scale and a rounding right shift, applies optional ReLU, and saturates to a signed OUT_WIDTH activation.
- Sits between the adder tree and the activation write-back buffer in each conv lane.

---
 rtl/conv_accum_requant.sv | 139 +++++++++++++
 tb/tb_conv_accum_requant.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_accum_requant.sv
// Per-lane conv back end: accumulates NUM_GROUPS partial sums per output pixel, adds bias,
// requantizes (scale, rounding shift), optional ReLU, and saturates to a signed activation.
module conv_accum_requant #(
  parameter int IN_WIDTH    = 21,
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_GROUPS  = 4,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int OUT_WIDTH   = 8,
  parameter int RELU        = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [IN_WIDTH-1:0]    i_data,
  input  logic                          i_valid,
  input  logic signed [BIAS_WIDTH-1:0]  i_bias,
  input  logic        [SCALE_WIDTH-1:0] i_scale,
  input  logic        [SHIFT_WIDTH-1:0] i_shift,
  output logic signed [OUT_WIDTH-1:0]   o_data,
  output logic                          o_valid
);

  localparam int CNT_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH + 1;
  // One extra bit so adding the rounding constant can never wrap the product.
  localparam int RND_W  = PROD_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_GROUPS - 1);

  localparam logic signed [RND_W-1:0] SAT_MAX =
    {{(RND_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN =
    {{(RND_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // Stage 0 state
  logic        [CNT_W-1:0]       r_count;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  // Stage 1 state
  logic signed [ACC_WIDTH-1:0]   r_s1;
  logic        [SCALE_WIDTH-1:0] r_scale1;
  logic        [SHIFT_WIDTH-1:0] r_shift1;
  logic                          r_v1;
  // Stage 2 state
  logic signed [PROD_W-1:0]      r_prod;
  logic        [SHIFT_WIDTH-1:0] r_shift2;
  logic                          r_v2;
  // Output registers
  logic signed [OUT_WIDTH-1:0]   r_out;
  logic                          r_out_valid;

  logic signed [ACC_WIDTH-1:0]   w_data_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_ext;
  logic signed [ACC_WIDTH-1:0]   w_acc_sum;
  logic                          w_last;
  logic        [RND_W-1:0]       w_half;
  logic signed [RND_W-1:0]       w_rounded;
  logic signed [RND_W-1:0]       w_shifted;
  logic signed [RND_W-1:0]       w_relu;
  logic signed [OUT_WIDTH-1:0]   w_sat;

  assign w_data_ext = ACC_WIDTH'(i_data);
  assign w_bias_ext = ACC_WIDTH'(i_bias);
  assign w_acc_sum  = r_acc + w_data_ext;
  assign w_last     = (r_count == LAST_BEAT);

  // Stage 0: accumulate one group; idle cycles leave count and accumulator untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_s1     <= '0;
      r_scale1 <= '0;
      r_shift1 <= '0;
      r_v1     <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      if (i_valid) begin
        if (w_last) begin
          r_s1     <= w_acc_sum + w_bias_ext;
          r_scale1 <= i_scale;
          r_shift1 <= i_shift;
          r_acc    <= '0;
          r_count  <= '0;
          r_v1     <= 1'b1;
        end else begin
          r_acc   <= w_acc_sum;
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  // Stage 1: signed sum times zero-extended unsigned scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_shift2 <= '0;
      r_v2     <= 1'b0;
    end else begin
      r_prod   <= PROD_W'(r_s1) * PROD_W'($signed({1'b0, r_scale1}));
      r_shift2 <= r_shift1;
      r_v2     <= r_v1;
    end
  end

  // Stage 2: round half toward +inf; a zero shift yields a zero rounding constant.
  always_comb begin
    w_half    = (RND_W'(1) << r_shift2) >> 1;
    w_rounded = RND_W'(r_prod) + $signed(w_half);
    w_shifted = w_rounded >>> r_shift2;
    w_relu    = ((RELU != 0) && (w_shifted < 0)) ? '0 : w_shifted;
    if (w_relu > SAT_MAX) begin
      w_sat = OUT_MAX;
    end else if (w_relu < SAT_MIN) begin
      w_sat = OUT_MIN;
    end else begin
      w_sat = w_relu[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_out <= w_sat;
      end
    end
  end

  assign o_data  = r_out;
  assign o_valid = r_out_valid;

endmodule

// File: tb/tb_conv_accum_requant.sv
// Directed bench for conv_accum_requant: vector table plus gap/back-to-back, reset and
// NUM_GROUPS=1 streaming sequences across three parameterizations sharing one stimulus.
module tb_conv_accum_requant;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [20:0]  i_data;
  logic                i_valid;
  logic signed [31:0]  i_bias;
  logic        [15:0]  i_scale;
  logic        [4:0]   i_shift;
  logic signed [7:0]   o_data_lin, o_data_relu, o_data_ng1;
  logic                o_valid_lin, o_valid_relu, o_valid_ng1;

  always #5 clk = ~clk;

  conv_accum_requant #(.NUM_GROUPS(4), .RELU(0)) u_dut_lin (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_bias(i_bias),
    .i_scale(i_scale), .i_shift(i_shift), .o_data(o_data_lin), .o_valid(o_valid_lin));

  conv_accum_requant #(.NUM_GROUPS(4), .RELU(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_bias(i_bias),
    .i_scale(i_scale), .i_shift(i_shift), .o_data(o_data_relu), .o_valid(o_valid_relu));

  conv_accum_requant #(.NUM_GROUPS(1), .RELU(0)) u_dut_ng1 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_bias(i_bias),
    .i_scale(i_scale), .i_shift(i_shift), .o_data(o_data_ng1), .o_valid(o_valid_ng1));

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int q_lin_d[$], q_lin_c[$], q_relu_d[$], q_ng1_d[$], q_ng1_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid_lin) begin
      q_lin_d.push_back(int'(o_data_lin));
      q_lin_c.push_back(cyc);
    end
    if (o_valid_relu) q_relu_d.push_back(int'(o_data_relu));
    if (o_valid_ng1) begin
      q_ng1_d.push_back(int'(o_data_ng1));
      q_ng1_c.push_back(cyc);
    end
  end

  typedef struct {
    int d0; int d1; int d2; int d3;
    int bias; int scale; int shift;
    int exp_lin; int exp_relu;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive(input bit v, input int d, input int b, input int sc, input int sh);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = 21'(d);
    i_bias  = 32'(b);
    i_scale = 16'(sc);
    i_shift = 5'(sh);
  endtask

  // Idle cycles carry junk data/config so that anything sampled while i_valid=0 shows up.
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 12345, int'($urandom), int'($urandom), int'($urandom));
  endtask

  task automatic clear_q();
    q_lin_d.delete(); q_lin_c.delete(); q_relu_d.delete();
    q_ng1_d.delete(); q_ng1_c.delete();
  endtask

  // Non-final beats carry random bias/scale/shift; only the final beat's must be used.
  task automatic apply_group(input int d0, input int d1, input int d2, input int d3,
                             input int b, input int sc, input int sh, input int gap_max,
                             output int final_cyc);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle(int'($urandom_range(gap_max, 0)));
      if (k < 3) drive(1'b1, d[k], int'($urandom), int'($urandom), int'($urandom));
      else       drive(1'b1, d[k], b, sc, sh);
    end
    final_cyc = cyc;
  endtask

  function automatic longint model(input longint s, input longint sc, input int sh, input bit relu);
    longint p;
    p = s * sc;
    if (sh > 0) p = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && p < 0) p = 0;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fc, fc_a, fc_b, first;

    vecs[0]  = '{100, 200, -50, 30, 20, 3, 4, 56, 56};
    vecs[1]  = '{10, 10, 2, 2, 0, 1, 4, 2, 2};
    vecs[2]  = '{20, 1, 1, 1, 0, 1, 4, 1, 1};
    vecs[3]  = '{-10, -10, -2, -2, 0, 1, 4, -1, 0};
    vecs[4]  = '{-8, 0, 0, 0, 0, 1, 4, 0, 0};
    vecs[5]  = '{5000, 5000, 0, 0, 0, 1, 0, 127, 127};
    vecs[6]  = '{-250, -250, 0, 0, 0, 1, 0, -128, 0};
    vecs[7]  = '{400, 300, 200, 100, 0, 65535, 20, 62, 62};
    vecs[8]  = '{-50, -50, 0, 0, 0, 40000, 16, -61, 0};
    vecs[9]  = '{-10, -10, -10, -10, 0, 1, 4, -2, 0};
    vecs[10] = '{1, 1, 1, 1, -1000, 1, 0, -128, 0};
    vecs[11] = '{0, 0, 0, 0, 77, 1, 0, 77, 77};

    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_bias = '0; i_scale = '0; i_shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_valid", o_valid_lin | o_valid_relu | o_valid_ng1, 0);
    check("reset o_data", o_data_lin, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 12; v++) begin
      clear_q();
      apply_group(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3,
                  vecs[v].bias, vecs[v].scale, vecs[v].shift, 0, fc);
      idle(6);
      check($sformatf("vec%0d count", v), q_lin_d.size(), 1);
      if (q_lin_d.size() > 0) begin
        check($sformatf("vec%0d lin", v), q_lin_d[0], vecs[v].exp_lin);
        check($sformatf("vec%0d latency", v), q_lin_c[0] - fc, 3);
      end
      if (q_relu_d.size() > 0) check($sformatf("vec%0d relu", v), q_relu_d[0], vecs[v].exp_relu);
      else check($sformatf("vec%0d relu count", v), q_relu_d.size(), 1);
    end

    // Two groups with random gaps; second starts the cycle after the first's final beat.
    clear_q();
    apply_group(10, 20, 30, 40, 5, 2, 1, 2, fc_a);
    apply_group(-1, -2, -3, -4, 100, 1, 0, 2, fc_b);
    idle(6);
    check("b2b count", q_lin_d.size(), 2);
    if (q_lin_d.size() == 2) begin
      check("b2b first", q_lin_d[0], 105);
      check("b2b second", q_lin_d[1], 90);
      check("b2b first latency", q_lin_c[0] - fc_a, 3);
      check("b2b second latency", q_lin_c[1] - fc_b, 3);
    end

    // Reset mid-group discards the partial sum.
    clear_q();
    drive(1'b1, 1000, 0, 1, 0);
    drive(1'b1, 1000, 0, 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("midreset o_valid", o_valid_lin, 0);
    check("midreset o_data", o_data_lin, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postreset o_valid", o_valid_lin, 0);
    apply_group(1, 1, 1, 1, 0, 1, 0, 0, fc);
    idle(6);
    check("postreset count", q_lin_d.size(), 1);
    if (q_lin_d.size() > 0) check("postreset value", q_lin_d[0], 4);

    // NUM_GROUPS=1: continuous stream in, continuous results out.
    idle(4);
    clear_q();
    first = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i * 37 - 100, -3, 5, 3);
      if (i == 0) first = cyc;
    end
    idle(6);
    check("ng1 count", q_ng1_d.size(), 8);
    for (int i = 0; i < 8 && i < q_ng1_d.size(); i++) begin
      check($sformatf("ng1 beat%0d value", i), q_ng1_d[i], model(i * 37 - 100 - 3, 5, 3, 1'b0));
      check($sformatf("ng1 beat%0d cycle", i), q_ng1_c[i] - first, i + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
